// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and sizing for the SRAM port arbiter.
// Imported by the arbiter top and its grant picker.
package sram_port_arbiter_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  localparam int SRAM_LAT_MAX = 4;
  localparam int WAIT_W = $clog2(SRAM_LAT_MAX + 1);
  localparam int STARVE_W = 8;
endpackage

// File: rtl/sram_port_arbiter_pick.sv
// Grant picker: LS priority with a starvation guard for IF.
// Holds the count of LS grants taken while IF was waiting.
module sram_arb_pick
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic idle,
  input  logic accept,
  output logic grant_if,
  output logic grant_ls
);
  localparam logic [STARVE_W-1:0] MAX =
    STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic ls_win;

  always_comb begin
    ls_win   = ls_valid &&
               (!if_valid || starve_cnt < MAX);
    grant_ls = idle && ls_win;
    grant_if = idle && if_valid && !ls_win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (grant_ls && if_valid)
        starve_cnt <= (starve_cnt < MAX) ?
                      starve_cnt + 1'b1 : MAX;
      else
        starve_cnt <= '0;
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between fetch (IF) and load/store (LS).
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int SRAM_LAT   = 1,
  parameter int STARVE_MAX = 3,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_req_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [31:0]       if_resp_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [31:0]       ls_req_addr,
  input  logic              ls_req_wen,
  input  logic [3:0]        ls_req_wstrb,
  input  logic [31:0]       ls_req_wdata,
  output logic              ls_resp_valid,
  input  logic              ls_resp_ready,
  output logic [31:0]       ls_resp_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
  state_t state, state_nx;
  owner_t owner;

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic idle, grant_if, grant_ls;
  logic accept, resp_hs, last_wait;
  logic unused_addr;

  assign unused_addr = ^{if_req_addr[31:ADDR_W+2],
                         if_req_addr[1:0],
                         ls_req_addr[31:ADDR_W+2],
                         ls_req_addr[1:0]};

  // Reset gates ready so nothing is offered while held.
  assign idle = (state == S_IDLE) && !reset;

  sram_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .reset   (reset),
    .if_valid(if_req_valid),
    .ls_valid(ls_req_valid),
    .idle    (idle),
    .accept  (accept),
    .grant_if(grant_if),
    .grant_ls(grant_ls)
  );

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign accept = (grant_if && if_req_valid) ||
                  (grant_ls && ls_req_valid);
  assign resp_hs = (state == S_RESP) &&
                   ((owner == OWN_IF) ? if_resp_ready
                                      : ls_resp_ready);
  assign last_wait = (state == S_WAIT) &&
                     (wait_cnt == WAIT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    sram_en       = 1'b0;
    sram_we       = '0;
    sram_addr     = '0;
    sram_wdata    = '0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    if_resp_rdata = '0;
    ls_resp_rdata = '0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        sram_en    = 1'b1;
        sram_addr  = addr_q;
        sram_we    = wen_q ? wstrb_q : 4'b0000;
        sram_wdata = wen_q ? wdata_q : '0;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        if (last_wait) state_nx = S_RESP;
      end
      S_RESP: begin
        if (owner == OWN_IF) begin
          if_resp_valid = 1'b1;
          if_resp_rdata = rdata_q;
        end else begin
          ls_resp_valid = 1'b1;
          ls_resp_rdata = rdata_q;
        end
        if (resp_hs) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= OWN_LS;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        owner   <= grant_ls ? OWN_LS : OWN_IF;
        addr_q  <= grant_ls ? ls_req_addr[ADDR_W+1:2]
                            : if_req_addr[ADDR_W+1:2];
        wen_q   <= grant_ls && ls_req_wen;
        wstrb_q <= grant_ls ? ls_req_wstrb : 4'b0000;
        wdata_q <= grant_ls ? ls_req_wdata : '0;
      end
      if (state == S_ISSUE)
        wait_cnt <= WAIT_W'(SRAM_LAT);
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt - 1'b1;
      if (last_wait)
        rdata_q <= wen_q ? '0 : sram_rdata;
    end
  end
endmodule
